// File: rtl/data_ram_if.sv
// data_ram_if
// Bundles the MEM-stage request signals and the RAM response signals.
//   ram_re, ram_we  : read / write request (one access per cycle)
//   ram_address     : byte address of the access
//   ram_data        : write data
//   ram_rdata       : registered read data for WB
//   ram_rvalid      : ram_rdata valid this cycle
//   ram_err         : previous-cycle access was misaligned or out of range
//   ram_busy        : clear sweep in progress, accesses ignored
// The master modport is the requester side; the slave modport is the RAM.
interface data_ram_if;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_data;
    logic [31:0] ram_rdata;
    logic        ram_rvalid;
    logic        ram_err;
    logic        ram_busy;

    modport master (
        output ram_re, ram_we, ram_address, ram_data,
        input  ram_rdata, ram_rvalid, ram_err, ram_busy
    );

    modport slave (
        input  ram_re, ram_we, ram_address, ram_data,
        output ram_rdata, ram_rvalid, ram_err, ram_busy
    );
endinterface

// File: rtl/data_ram.sv
// data_ram
// Word-addressed data RAM (2^ADDR_W x 32 bits) for the MEM stage. After
// every reset it runs a clear sweep that zeroes the whole array, one word
// per cycle, while ram_busy is high. Once READY it serves one read and/or
// write per cycle. Reads have a latency of one cycle and are write-first.
// Misaligned or out-of-range accesses never touch the array and raise
// ram_err for one cycle.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : data_ram_if slave modport (request in, response out)
module data_ram #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    data_ram_if.slave    bus
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;

    logic              legal;
    logic [ADDR_W-1:0] index;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    // Any set bit above the array range makes the access illegal, so an
    // out-of-range address can never alias onto a real word.
    assign legal = (bus.ram_address[1:0] == 2'b00) &&
                   (bus.ram_address[31:ADDR_W+2] == '0);
    assign index = bus.ram_address[ADDR_W+1:2];

    // Single array write port shared by the clear sweep and normal writes.
    // Reset blocks every write, including the sweep's own.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_cnt;
        mem_wdata = 32'h0;
        if (!rst) begin
            if (state == INIT) begin
                mem_we = 1'b1;
            end else if (bus.ram_we && legal) begin
                mem_we    = 1'b1;
                mem_waddr = index;
                mem_wdata = bus.ram_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM and registered response. A read that coincides with a
    // legal write to the same word forwards the write data (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            rdata   <= 32'h0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    rvalid  <= 1'b0;
                    err     <= 1'b0;
                    clr_cnt <= clr_cnt + CNT_ONE;
                    if (clr_cnt == '1) begin
                        state <= READY;
                    end
                end
                READY: begin
                    rvalid <= bus.ram_re;
                    err    <= (bus.ram_re || bus.ram_we) && !legal;
                    if (bus.ram_re) begin
                        if (!legal) begin
                            rdata <= 32'h0;
                        end else if (bus.ram_we) begin
                            rdata <= bus.ram_data;
                        end else begin
                            rdata <= mem[index];
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign bus.ram_rdata  = rdata;
    assign bus.ram_rvalid = rvalid;
    assign bus.ram_err    = err;
    assign bus.ram_busy   = (state == INIT);

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram
// Self-checking bench for data_ram. Accesses in READY are driven through
// applyStimulus, which updates a reference memory model and pushes the
// expected response onto a scoreboard queue; the entry is popped and
// compared one cycle later. Sweep timing and reset behaviour are checked
// by counting cycles directly.
module tb_data_ram;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        rvalid;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;

    data_ram_if bus ();

    data_ram #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks;
    int          failures;
    exp_t        sb [$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic driveIdle();
        bus.ram_re      = 1'b0;
        bus.ram_we      = 1'b0;
        bus.ram_address = 32'h0;
        bus.ram_data    = 32'h0;
    endtask

    // One READY-state access: drive at the falling edge, model the effect,
    // let the rising edge consume it, compare at the next falling edge.
    task automatic applyStimulus(input string tag, input logic re, input logic we,
                                 input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        logic lgl;
        int   idx;
        bus.ram_re      = re;
        bus.ram_we      = we;
        bus.ram_address = addr;
        bus.ram_data    = data;
        lgl = (addr[1:0] == 2'b00) && (addr[31:12] == 20'h0);
        idx = int'(addr[11:2]);
        if (we && lgl) model_mem[idx] = data;
        if (re) model_rdata = lgl ? model_mem[idx] : 32'h0;
        e.tag    = tag;
        e.rdata  = model_rdata;
        e.rvalid = re;
        e.err    = (re || we) && !lgl;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        driveIdle();
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({e.tag, "_rvalid"}, {31'h0, bus.ram_rvalid}, {31'h0, e.rvalid});
            checkOutput({e.tag, "_err"},    {31'h0, bus.ram_err},    {31'h0, e.err});
            checkOutput({e.tag, "_rdata"},  bus.ram_rdata,           e.rdata);
        end
    endtask

    // Reset with a read/write pending on the bus; reset must win and the
    // response registers must come out cleared.
    task automatic doReset(input string tag);
        @(negedge clk);
        rst             = 1'b1;
        bus.ram_re      = 1'b1;
        bus.ram_we      = 1'b1;
        bus.ram_address = 32'h0000_0040;
        bus.ram_data    = 32'hFFFF_0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        driveIdle();
        sb.delete();
        model_rdata = 32'h0;
        checkOutput({tag, "_rst_rvalid"}, {31'h0, bus.ram_rvalid}, 32'h0);
        checkOutput({tag, "_rst_err"},    {31'h0, bus.ram_err},    32'h0);
        checkOutput({tag, "_rst_rdata"},  bus.ram_rdata,           32'h0);
        checkOutput({tag, "_rst_busy"},   {31'h0, bus.ram_busy},   32'h1);
    endtask

    // Run n sweep cycles, counting any cycle in which busy was already low.
    // Cycle 10 carries an access that must be ignored.
    task automatic sweepCycles(input string tag, input int n);
        int low_seen;
        low_seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.ram_busy !== 1'b1) low_seen++;
            if (i == 10) begin
                bus.ram_re      = 1'b1;
                bus.ram_we      = 1'b1;
                bus.ram_address = 32'h0000_0080;
                bus.ram_data    = 32'hFFFF_FFFF;
            end
            @(posedge clk);
            @(negedge clk);
            if (i == 10) begin
                driveIdle();
                checkOutput({tag, "_busy_rvalid"}, {31'h0, bus.ram_rvalid}, 32'h0);
                checkOutput({tag, "_busy_err"},    {31'h0, bus.ram_err},    32'h0);
            end
        end
        checkOutput({tag, "_busy_low_early"}, low_seen, 32'd0);
    endtask

    task automatic finishSweep(input string tag);
        sweepCycles(tag, DEPTH);
        checkOutput({tag, "_busy_after"}, {31'h0, bus.ram_busy}, 32'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_rdata = 32'h0;
        rst         = 1'b1;
        driveIdle();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        doReset("r1");
        finishSweep("sw1");

        applyStimulus("rd_000", 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        applyStimulus("rd_ffc", 1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
        applyStimulus("rd_080", 1'b1, 1'b0, 32'h0000_0080, 32'h0);

        applyStimulus("wr_010", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        applyStimulus("rd_010", 1'b1, 1'b0, 32'h0000_0010, 32'h0);

        applyStimulus("rw_020", 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
        applyStimulus("rd_020", 1'b1, 1'b0, 32'h0000_0020, 32'h0);

        applyStimulus("wr_002", 1'b0, 1'b1, 32'h0000_0002, 32'h0000_0055);
        applyStimulus("rd_1000", 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        applyStimulus("idle", 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus("rd_000b", 1'b1, 1'b0, 32'h0000_0000, 32'h0);

        applyStimulus("wr_hi", 1'b0, 1'b1, 32'h8000_0010, 32'h1111_1111);
        applyStimulus("rd_010b", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        applyStimulus("idle_hold", 1'b0, 1'b0, 32'h0, 32'h0);

        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = {20'h0, 10'($urandom_range(DEPTH - 1)), 2'b00};
            d = $urandom;
            applyStimulus("rnd_wr", 1'b0, 1'b1, a, d);
            applyStimulus("rnd_rd", 1'b1, 1'b0, a, 32'h0);
        end
        applyStimulus("wr_ffc", 1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D);
        applyStimulus("rd_ffcb", 1'b1, 1'b0, 32'h0000_0FFC, 32'h0);

        applyStimulus("wr_040", 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5);
        applyStimulus("rd_040", 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        doReset("r2");
        sweepCycles("sw2_part", 500);
        doReset("r3");
        finishSweep("sw3");
        applyStimulus("rd_040z", 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        applyStimulus("rd_010z", 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        applyStimulus("rd_ffcz", 1'b1, 1'b0, 32'h0000_0FFC, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
